// File: rtl/delay_readback_pkg.sv
// Shared definitions for the delay-line readback path: FSM encoding,
// Q8.8 gain constants and the 16-bit saturation helper.
package delay_readback_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    SCALE = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [15:0] GAIN_UNITY = 16'h0100;
  localparam logic [15:0] SAT_MAX    = 16'h7FFF;
  localparam logic [15:0] SAT_MIN    = 16'h8000;

  // Clamp a wide signed value into the signed 16-bit sample range.
  // The value fits when every bit from 32 down to 15 equals the sign bit.
  function automatic logic [15:0] saturate16(input logic signed [32:0] value);
    if (value[32:15] == {18{value[32]}}) begin
      return value[15:0];
    end else if (value[32]) begin
      return SAT_MIN;
    end else begin
      return SAT_MAX;
    end
  endfunction

endpackage

// File: rtl/delay_readback_gain_scale.sv
// gain_scale: signed sample times unsigned Q8.8 gain, arithmetic shift by 8,
// saturated back to a signed 16-bit sample. Purely combinational so the
// recording path can share it.
module gain_scale
  import delay_readback_pkg::*;
(
  input  logic [15:0] data_in,
  input  logic [15:0] gain,
  output logic [15:0] data_out
);

  logic signed [32:0] product;
  logic signed [32:0] shifted;

  // Multiply as 33-bit signed (gain zero-extended), scale down, then clamp.
  // Unity gain takes the direct path; the product path yields the same value.
  always_comb begin
    product = $signed({{17{data_in[15]}}, data_in}) * $signed({17'd0, gain});
    shifted = product >>> 8;
    if (gain == GAIN_UNITY) begin
      data_out = data_in;
    end else begin
      data_out = saturate16(shifted);
    end
  end

endmodule

// File: rtl/delay_readback.sv
// delay_readback: on each sample-rate strobe, reads the delayed sample from
// memory (write pointer minus delay), scales it by the playback gain and
// presents it with a one-cycle valid pulse. Reads that never complete are
// abandoned after TIMEOUT_CYCLES and report a zero sample.
module delay_readback
  import delay_readback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adc_clock,
  input  logic              enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [15:0]       delay_reverb,
  input  logic [15:0]       gain,
  input  logic              mem_ready,
  input  logic [15:0]       mem_data_in,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              sync3_q, sync3_d;
  logic [1:0]        fill_q, fill_d;
  logic              armed_q, armed_d;
  logic              tick_q, tick_d;

  state_t            state_q, state_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       scaled_q, scaled_d;
  logic [15:0]       sample_out_q, sample_out_d;
  logic              sample_valid_q, sample_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       scaled_w;

  gain_scale u_gain_scale (
    .data_in  (data_q),
    .gain     (gain),
    .data_out (scaled_w)
  );

  // Strobe synchronizer and edge detect. The edge only counts once sync2 has
  // held a genuinely sampled low level, so a strobe already high at reset
  // release does not produce a phantom tick.
  always_comb begin
    sync1_d = adc_clock;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~sync2_q);
    tick_d  = sync2_q & ~sync3_q & armed_q;
  end

  // Readback sequencer: request, wait with timeout, scale, present.
  always_comb begin
    state_d        = state_q;
    mem_re_d       = mem_re_q;
    mem_addr_d     = mem_addr_q;
    timer_d        = timer_q;
    data_d         = data_q;
    scaled_d       = scaled_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    timeout_err_d  = 1'b0;
    overrun_d      = tick_q & (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (tick_q && enable) begin
          state_d = REQ;
        end
      end
      REQ: begin
        mem_addr_d = write_addr - ADDR_W'(delay_reverb);
        mem_re_d   = 1'b1;
        timer_d    = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          data_d   = mem_data_in;
          mem_re_d = 1'b0;
          state_d  = SCALE;
        end else if (timer_q == TIMER_LAST) begin
          mem_re_d       = 1'b0;
          timeout_err_d  = 1'b1;
          sample_out_d   = '0;
          sample_valid_d = 1'b1;
          state_d        = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SCALE: begin
        scaled_d = scaled_w;
        state_d  = OUT;
      end
      OUT: begin
        sample_out_d   = scaled_q;
        sample_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      fill_q         <= '0;
      armed_q        <= 1'b0;
      tick_q         <= 1'b0;
      state_q        <= IDLE;
      mem_re_q       <= 1'b0;
      mem_addr_q     <= '0;
      timer_q        <= '0;
      data_q         <= '0;
      scaled_q       <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      sync3_q        <= sync3_d;
      fill_q         <= fill_d;
      armed_q        <= armed_d;
      tick_q         <= tick_d;
      state_q        <= state_d;
      mem_re_q       <= mem_re_d;
      mem_addr_q     <= mem_addr_d;
      timer_q        <= timer_d;
      data_q         <= data_d;
      scaled_q       <= scaled_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      timeout_err_q  <= timeout_err_d;
      overrun_q      <= overrun_d;
    end
  end

  assign mem_re       = mem_re_q;
  assign mem_addr     = mem_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_delay_readback.sv
// Directed bench for delay_readback: address arithmetic, gain scaling and
// saturation, handshake latency, timeout, overrun and reset behaviour.
module tb_delay_readback;

  logic        clk;
  logic        rst_n;
  logic        adc_clock;
  logic        enable;
  logic [15:0] write_addr;
  logic [15:0] delay_reverb;
  logic [15:0] gain;
  logic        mem_ready;
  logic [15:0] mem_data_in;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        timeout_err;
  logic        overrun;

  int compared;
  int mismatched;

  delay_readback #(
    .TIMEOUT_CYCLES (255),
    .ADDR_W         (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .adc_clock    (adc_clock),
    .enable       (enable),
    .write_addr   (write_addr),
    .delay_reverb (delay_reverb),
    .gain         (gain),
    .mem_ready    (mem_ready),
    .mem_data_in  (mem_data_in),
    .mem_re       (mem_re),
    .mem_addr     (mem_addr),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the strobe level and the recording-path inputs together.
  task automatic applyStimulus(input logic adc_level, input logic en,
                               input logic [15:0] waddr, input logic [15:0] dly,
                               input logic [15:0] g);
    adc_clock    = adc_level;
    enable       = en;
    write_addr   = waddr;
    delay_reverb = dly;
    gain         = g;
  endtask

  // Wait (bounded) for mem_re; returns the number of negedges waited.
  task automatic waitMemRe(output int cycles);
    cycles = 20;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_re) begin
        cycles = i;
        break;
      end
    end
  endtask

  // One complete read: strobe edge, address check, handshake, scaled result.
  task automatic runRead(input string tag, input logic [15:0] waddr,
                         input logic [15:0] dly, input logic [15:0] g,
                         input logic [15:0] data, input logic [15:0] exp_addr,
                         input logic [15:0] exp_out);
    int n;
    applyStimulus(1'b1, 1'b1, waddr, dly, g);
    mem_data_in = data;
    waitMemRe(n);
    checkOutput({tag, "_latency"}, n, 5);
    checkOutput({tag, "_addr"}, mem_addr, exp_addr);
    applyStimulus(1'b0, 1'b1, waddr ^ 16'h5A5A, dly ^ 16'h0F0F, g);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_re_held"}, mem_re, 1);
    checkOutput({tag, "_addr_stable"}, mem_addr, exp_addr);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready   = 1'b0;
    mem_data_in = 16'hDEAD;
    checkOutput({tag, "_re_drop"}, mem_re, 0);
    checkOutput({tag, "_valid_early1"}, sample_valid, 0);
    @(negedge clk);
    checkOutput({tag, "_valid_early2"}, sample_valid, 0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, sample_valid, 1);
    checkOutput({tag, "_value"}, sample_out, exp_out);
    @(negedge clk);
    checkOutput({tag, "_valid_pulse"}, sample_valid, 0);
    checkOutput({tag, "_hold"}, sample_out, exp_out);
  endtask

  initial begin
    int n;
    int hits;
    int vals;
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    mem_ready   = 1'b0;
    mem_data_in = 16'h0000;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);

    repeat (2) @(negedge clk);
    checkOutput("rst_mem_re", mem_re, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_sample_out", sample_out, 0);
    checkOutput("rst_sample_valid", sample_valid, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    runRead("unity", 16'h0100, 16'h0040, 16'h0100, 16'h4000, 16'h00C0, 16'h4000);
    runRead("wrap_sat_pos", 16'h0010, 16'h0020, 16'h0400, 16'h4000, 16'hFFF0, 16'h7FFF);
    runRead("zero_dly_sat_neg", 16'h1234, 16'h0000, 16'h0400, 16'hC000, 16'h1234, 16'h8000);
    runRead("half_gain", 16'h0200, 16'h0001, 16'h0080, 16'h1234, 16'h01FF, 16'h091A);
    runRead("neg_floor", 16'h0000, 16'h0001, 16'h0080, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    $display("[TB] strobe with enable low, stray mem_ready while idle");
    applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0001, 16'h0100);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_re || sample_valid || overrun) hits++;
    end
    checkOutput("disabled_tick_ignored", hits, 0);
    applyStimulus(1'b0, 1'b0, 16'h0300, 16'h0001, 16'h0100);
    mem_ready = 1'b1;
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_re || sample_valid) hits++;
    end
    mem_ready = 1'b0;
    checkOutput("idle_ready_ignored", hits, 0);

    $display("[TB] second strobe during WAIT, enable dropped mid-read");
    applyStimulus(1'b1, 1'b1, 16'h0300, 16'h0100, 16'h0100);
    mem_data_in = 16'h0100;
    waitMemRe(n);
    checkOutput("ovr_latency", n, 5);
    applyStimulus(1'b0, 1'b1, 16'h0300, 16'h0100, 16'h0100);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0100, 16'h0100);
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (overrun) hits++;
    end
    checkOutput("ovr_pulse_count", hits, 1);
    checkOutput("ovr_read_not_aborted", mem_re, 1);
    applyStimulus(1'b0, 1'b1, 16'h0300, 16'h0100, 16'h0100);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    vals = 0;
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (sample_valid) vals++;
      if (mem_re) hits++;
    end
    checkOutput("ovr_single_valid", vals, 1);
    checkOutput("ovr_no_queued_read", hits, 0);
    checkOutput("ovr_value", sample_out, 16'h0100);

    $display("[TB] read with no mem_ready");
    applyStimulus(1'b1, 1'b1, 16'h0400, 16'h0010, 16'h0100);
    waitMemRe(n);
    checkOutput("to_latency", n, 5);
    checkOutput("to_addr", mem_addr, 16'h03F0);
    applyStimulus(1'b0, 1'b1, 16'h0400, 16'h0010, 16'h0100);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!mem_re) break;
      n++;
    end
    checkOutput("to_wait_cycles", n, 255);
    checkOutput("to_err_pulse", timeout_err, 1);
    checkOutput("to_valid_pulse", sample_valid, 1);
    checkOutput("to_sample_zero", sample_out, 16'h0000);
    checkOutput("to_mem_re_low", mem_re, 0);
    @(negedge clk);
    checkOutput("to_err_one_cycle", timeout_err, 0);
    checkOutput("to_valid_one_cycle", sample_valid, 0);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b1, 16'h0500, 16'h0020, 16'h0100);
    mem_data_in = 16'h7777;
    waitMemRe(n);
    checkOutput("rw_latency", n, 5);
    applyStimulus(1'b0, 1'b1, 16'h0500, 16'h0020, 16'h0100);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rw_mem_re_async", mem_re, 0);
    checkOutput("rw_mem_addr_async", mem_addr, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (sample_valid || mem_re) hits++;
    end
    checkOutput("rw_abandoned", hits, 0);

    $display("[TB] strobe held high across reset release");
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'h0600, 16'h0000, 16'h0100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_re || overrun) hits++;
    end
    checkOutput("no_phantom_tick", hits, 0);
    applyStimulus(1'b0, 1'b1, 16'h0600, 16'h0000, 16'h0100);
    repeat (3) @(negedge clk);
    runRead("first_real_edge", 16'h0600, 16'h0000, 16'h0100, 16'h2222, 16'h0600, 16'h2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/delay_readback.md
DELAY_READBACK -- requirements
Module: delay_readback

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max clk cycles waited for mem_ready per read.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 adc_clock  input  1  sample-rate strobe, asynchronous to clk.
REQ-006 enable  input  1  playback enable (high = reads issued).
REQ-007 write_addr  input  ADDR_W  current write pointer of the recording path.
REQ-008 delay_reverb  input  16  delay in samples behind write_addr.
REQ-009 gain  input  16  unsigned Q8.8 playback gain, 0x0100 = unity.
REQ-010 mem_ready  input  1  memory read-data-valid handshake.
REQ-011 mem_data_in  input  16  signed sample read from memory.
REQ-012 mem_re  output  1  read request, held until mem_ready.
REQ-013 mem_addr  output  ADDR_W  read address, stable while mem_re high.
REQ-014 sample_out  output  16  signed gain-scaled sample.
REQ-015 sample_valid  output  1  one-cycle pulse, sample_out updated.
REQ-016 timeout_err  output  1  one-cycle pulse, read abandoned.
REQ-017 overrun  output  1  one-cycle pulse, adc_clock edge dropped while busy.

Function
REQ-018 adc_clock SHALL pass a 2-flop synchronizer then rising-edge detect, yielding a one-cycle tick 3 clk cycles after the edge.
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, SCALE, OUT.
REQ-020 IDLE -> REQ on tick with enable=1; tick with enable=0 SHALL be ignored with no output.
REQ-021 In REQ, mem_addr SHALL latch (write_addr - delay_reverb) mod 2^ADDR_W, mem_re asserts; next state WAIT.
REQ-022 delay_reverb=0 SHALL read write_addr itself; delay_reverb > write_addr SHALL wrap.
REQ-023 In WAIT, mem_re SHALL stay high; mem_ready=1 captures mem_data_in, deasserts mem_re next cycle, goes SCALE.
REQ-024 mem_ready while mem_re low SHALL be ignored.
REQ-025 WAIT counter reaching TIMEOUT_CYCLES without mem_ready SHALL drop mem_re, pulse timeout_err, force sample_out=0 with sample_valid, return IDLE.
REQ-026 SCALE SHALL compute signed(data) x unsigned(gain) as 33-bit product, arithmetic shift right 8, saturate to [-32768, 32767].
REQ-027 OUT SHALL register sample_out, pulse sample_valid one cycle, return IDLE.
REQ-028 Latency mem_ready-capture to sample_valid SHALL be exactly 2 clk cycles.
REQ-029 Tick arriving in any state but IDLE SHALL be dropped and pulse overrun; no queueing.
REQ-030 enable falling mid-read SHALL not abort; current read completes.
REQ-031 sample_out SHALL hold its value between sample_valid pulses.
REQ-032 gain, delay_reverb, write_addr SHALL be sampled only in REQ (delay) and SCALE (gain).

Reset
REQ-033 rst_n low SHALL immediately force IDLE, mem_re=0, mem_addr=0, sample_out=0, sample_valid=0, timeout_err=0, overrun=0, synchronizer flops=0, timeout counter=0.
REQ-034 Reset mid-read SHALL abandon the transaction; no sample_valid after release for that read.
REQ-035 First tick SHALL be recognised only from a real adc_clock rising edge after reset release.

Structure
REQ-036 Shared package SHALL hold the FSM state encoding, Q8.8 unity constant 0x0100, and saturation limits 16'h7FFF/16'h8000.
REQ-037 One sub-module gain_scale (combinational multiply, shift, saturate) SHALL be instantiated in SCALE path; reused by the recording path.

Verification
REQ-038 write_addr=0x0100, delay_reverb=0x0040, adc edge -> mem_addr=0x00C0, mem_re high until mem_ready.
REQ-039 write_addr=0x0010, delay_reverb=0x0020 -> mem_addr=0xFFF0 (wrap).
REQ-040 mem_data_in=0x4000, gain=0x0100 -> sample_out=0x4000 two cycles after mem_ready; gain=0x0400 -> 0x7FFF; mem_data_in=0xC000, gain=0x0400 -> 0x8000.
REQ-041 mem_ready never asserted -> timeout_err pulse at cycle 255 of WAIT, sample_out=0x0000, sample_valid pulse, mem_re low.
REQ-042 Second adc edge during WAIT -> overrun pulse, single sample_valid only.
REQ-043 rst_n low during WAIT -> mem_re=0 immediately, no sample_valid after release until new adc edge.
